// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit producing a 64-bit HI/LO result, one iteration per cycle.
// Signed MULT/DIV are available only when MULDIV_SIGNED_EN is defined; otherwise every op is unsigned.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               dz;

    logic [WIDTH-1:0]   a_mag_in;
    logic [WIDTH-1:0]   b_mag_in;
    logic               dz_in;
    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign dz_in  = op[1] && (src_b == '0);
    assign accept = start && !cancel && (state == S_IDLE || state == S_DONE);
    assign last   = (state == S_RUN) && (dz || cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_SIGNED_EN
    logic a_neg_in, b_neg_in;
    logic neg_res, neg_rem;

    assign a_neg_in = op[0] & src_a[WIDTH-1];
    assign b_neg_in = op[0] & src_b[WIDTH-1];
    assign a_mag_in = a_neg_in ? -src_a : src_a;
    assign b_mag_in = b_neg_in ? -src_b : src_b;

    // Product/quotient sign is the XOR of operand signs; remainder follows the dividend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
        end else if (accept) begin
            neg_res <= a_neg_in ^ b_neg_in;
            neg_rem <= a_neg_in;
        end
    end
`else
    logic unused_op0;

    assign unused_op0 = op[0];
    assign a_mag_in   = src_a;
    assign b_mag_in   = src_b;
`endif

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   mul_up;
    logic [WIDTH:0]   div_shl;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;

    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    assign mul_up   = acc[0] ? mul_sum : {1'b0, acc[2*WIDTH-1:WIDTH]};
    assign div_shl  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = div_shl >= {1'b0, opnd};
    assign div_diff = div_shl[WIDTH-1:0] - opnd;

    always_comb begin
        acc_next = {mul_up, acc[WIDTH-1:1]};
        if (is_div)
            acc_next = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                              : {div_shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        {res_hi, res_lo} = acc_next;
        if (dz) begin
            {res_hi, res_lo} = acc;
        end else if (is_div) begin
`ifdef MULDIV_SIGNED_EN
            res_lo = neg_res ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
            res_hi = neg_rem ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
`else
            res_lo = acc_next[WIDTH-1:0];
            res_hi = acc_next[2*WIDTH-1:WIDTH];
`endif
        end else begin
`ifdef MULDIV_SIGNED_EN
            {res_hi, res_lo} = neg_res ? -acc_next : acc_next;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (accept) begin
            state  <= S_RUN;
            cnt    <= '0;
            opnd   <= b_mag_in;
            is_div <= op[1];
            dz     <= dz_in;
            // A zero divisor preloads the final result so the single RUN cycle just copies it.
            acc    <= dz_in ? {src_a, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, a_mag_in};
        end else if (state == S_RUN) begin
            if (cancel) begin
                state <= S_IDLE;
            end else if (last) begin
                state <= S_DONE;
                hi    <= res_hi;
                lo    <= res_lo;
            end else begin
                cnt <= cnt + 1'b1;
                acc <= acc_next;
            end
        end else if (state == S_DONE) begin
            state <= S_IDLE;
        end
    end

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign div_by_zero = done & dz;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; expectations follow MULDIV_SIGNED_EN when defined.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] MULTU = 2'd0, MULT = 2'd1, DIVU = 2'd2, DIV = 2'd3;

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start one op, wait (bounded) for done, check latency, busy coverage and results.
    task automatic run_op(input string tag, input logic [1:0] op_i, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz);
        int cyc;
        int busy_low;
        @(negedge clk);
        start = 1'b1; op = op_i; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        busy_low = 0;
        while (!done && cyc < 100) begin
            if (!busy) busy_low++;
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_busy_run"}, 64'(busy_low), 64'd0);
        chk({tag, "_busy_done"}, {63'd0, busy}, 64'd1);
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
        chk({tag, "_dz"}, {63'd0, div_by_zero}, {63'd0, exp_dz});
        @(posedge clk); #1;
        chk({tag, "_done_after"}, {63'd0, done}, 64'd0);
        chk({tag, "_dz_after"}, {63'd0, div_by_zero}, 64'd0);
        chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int cyc;
        int early;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dz", {63'd0, div_by_zero}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
`ifdef MULDIV_SIGNED_EN
        run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000, 1'b0);
        run_op("div_negb", DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("mult_2neg", MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 33, 32'h0, 32'd20, 1'b0);
`else
        run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 33, 32'h0000_0006, 32'hFFFF_FFEB, 1'b0);
        run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'd1, 32'h7FFF_FFFC, 1'b0);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'h0, 1'b0);
        run_op("div_negb", DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'd7, 32'h0, 1'b0);
        run_op("mult_2neg", MULT, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 33, 32'hFFFF_FFF7, 32'd20, 1'b0);
`endif
        run_op("divu_zero", DIVU, 32'h0000_1234, 32'd0, 2, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        run_op("div_zero", DIV, 32'hFFFF_FFFB, 32'd0, 2, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        run_op("divu_100_7", DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, 1'b0);

        // Cancel at cycle 10 of a DIVU; result registers must keep 2/14.
        @(negedge clk);
        start = 1'b1; op = DIVU; src_a = 32'd1000; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("cancel_busy_before", {63'd0, busy}, 64'd1);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("cancel_busy", {63'd0, busy}, 64'd0);
        chk("cancel_done", {63'd0, done}, 64'd0);
        chk("cancel_hilo", {hi, lo}, {32'd2, 32'd14});
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b1; op = DIVU; src_a = 32'd45; src_b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 13;
        early = 0;
        while (!done && cyc < 120) begin
            if (cyc == 30) chk("cancel_hilo_run", {hi, lo}, {32'd2, 32'd14});
            @(posedge clk); #1;
            cyc++;
        end
        chk("restart_lat", 64'(cyc), 64'd45);
        chk("restart_hilo", {hi, lo}, {32'd3, 32'd7});
        @(posedge clk); #1;

        // Back-to-back with start held high; mid-run operand changes must not be re-sampled.
        @(negedge clk);
        start = 1'b1; op = MULTU; src_a = 32'd5; src_b = 32'd6;
        @(posedge clk); #1;
        op = DIVU; src_a = 32'd100; src_b = 32'd7;
        cyc = 1;
        while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk("b2b_lat1", 64'(cyc), 64'd33);
        chk("b2b_hilo1", {hi, lo}, {32'd0, 32'd30});
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        chk("b2b_done_gap", {63'd0, done}, 64'd0);
        cyc = 1;
        while (!done && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk("b2b_lat2", 64'(cyc), 64'd33);
        chk("b2b_hilo2", {hi, lo}, {32'd2, 32'd14});
        @(posedge clk); #1;

        // Asynchronous reset mid-RUN.
        @(negedge clk);
        start = 1'b1; op = MULTU; src_a = 32'd3; src_b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", MULTU, 32'd3, 32'd4, 33, 32'd0, 32'd12, 1'b0);

        if (early != 0) chk("early", 64'(early), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit directly downstream of the register file.
- Consumes the two read ports (read1 → src_a, read2 → src_b) and produces a 64-bit HI/LO result that the writeback path returns to the register file.
- Runs one radix-2 iteration per cycle, so the pipeline stalls on busy.
- Also replaces a single-cycle combinational multiplier/divider on the critical path.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled on posedge.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- src_a  input  WIDTH  multiplicand / dividend (register file read1).
- src_b  input  WIDTH  multiplier / divisor (register file read2).
- cancel  input  1  abort the operation in flight (pipeline flush).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when HI/LO are valid.
- hi  output  WIDTH  product upper half / remainder.
- lo  output  WIDTH  product lower half / quotient.
- div_by_zero  output  1  high with done when a DIV/DIVU divisor was 0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0.
- States and transitions:
  - IDLE: start=1 captures op, src_a, src_b and moves to RUN.
  - RUN: counter runs 0..WIDTH-1, one iteration per cycle. After iteration WIDTH-1, goes to DONE.
  - DONE: asserts done for exactly one cycle, then returns to IDLE.
  - start=1 in DONE is accepted (back-to-back operation), next state RUN.
- Latency:
  - Start accepted at edge N gives done=1 during cycle N+WIDTH+1; 33 cycles for WIDTH=32.
  - busy=1 from N+1 through the done cycle inclusive.
- Start is ignored while in RUN; operands are not re-sampled.
- hi/lo:
  - Updated only on entry to DONE.
  - Held stable until the next completed operation. Cancel, a new start and RUN leave them unchanged.
- Multiply:
  - Shift-add on magnitudes.
  - Signed (MULT) negates the 2·WIDTH-bit product when the operand signs differ.
  - {hi,lo} = full product; no overflow possible.
- Divide:
  - Restoring division on magnitudes; lo = quotient, hi = remainder.
  - Signed (DIV): quotient is negative when the signs differ; the remainder takes the sign of the dividend (truncation toward zero).
  - Signed overflow (0x80000000 / 0xFFFFFFFF) gives lo=0x80000000, hi=0, with no flag.
- Divide by zero:
  - Detected at capture. The unit skips RUN: RUN→DONE after one cycle, so done appears at N+2.
  - Results: lo = all ones, hi = src_a as captured, div_by_zero=1 in the done cycle only.
- cancel:
  - In RUN: next state IDLE, busy=0 next cycle, done never pulses, hi/lo unchanged.
  - In IDLE/DONE: ignored.
  - cancel and start in the same cycle: cancel wins; the start is dropped.
- Reset mid-operation: immediate return to the reset values listed above.
- div_by_zero is 0 whenever done is 0.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Defined: op[0] selects signed MULT/DIV as described above.
- Undefined:
  - op[0] is ignored; all operations are unsigned (MULT behaves as MULTU, DIV as DIVU).
  - Sign-fixup logic is removed.
  - Latency and the divide-by-zero behaviour are unchanged.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → done at cycle 33; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1..33.
- MULT -3 (0xFFFFFFFD) × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Without MULDIV_SIGNED_EN → hi=0x00000006, lo=0xFFFFFFEB.
- DIV -7 / 2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100 / 7 → lo=14, hi=2.
- DIVU 0x1234 / 0 → done at cycle 2, div_by_zero=1, lo=0xFFFFFFFF, hi=0x00001234; div_by_zero=0 in the following cycle.
- Cancel during a DIVU (cancel at cycle 10):
  - busy=0 at cycle 11; no done pulse; hi/lo keep the previous result.
  - A new start at cycle 12 completes normally at cycle 45.
- Back-to-back and reset:
  - start held high through a done cycle → the second operation starts immediately, its done 33 cycles later.
  - start pulses during RUN are ignored.
  - rst_n low mid-RUN → all outputs 0 immediately, asynchronously.
